// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop synchronizer, falling-edge start detect,
// mid-bit sampling, with sticky ready/overrun flags and a framing-error flag.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 43
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam int unsigned HALF = BAUD_DIV / 2;
  localparam int unsigned CW   = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rdy_q, rdy_d;
  logic          frm_err_q, frm_err_d;
  logic          ovr_q, ovr_d;
  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic          start_edge;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
      ovr_q      <= ovr_d;
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
    end
  end

  // A start needs a high-to-low transition, so a line stuck low after a bad stop bit cannot retrigger.
  assign start_edge = (state_q == IDLE) && rx_s3_q && !rx_s2_q;

  // NOTE: every signal gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + CNT_ONE;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q & ~clr_rdy;
    ovr_d      = ovr_q & ~clr_rdy;
    frm_err_d  = frm_err_q;

    unique case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (baud_cnt_q == HALF_M1) begin
          baud_cnt_d = '0;
          if (rx_s2_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (baud_cnt_q == BAUD_M1) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_cnt_q == BAUD_M1) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          if (rx_s2_q) begin
            // A completed byte overrides a coincident clr_rdy; overrun looks at the pre-clear rdy.
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            frm_err_d = 1'b0;
            if (rdy_q) ovr_d = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;
  assign ovr     = ovr_q;

endmodule
